// File: rtl/lpc_reg_pkg.sv
// Shared types and helpers for the LPC register bank: lock FSM encoding,
// default key/lock constants and a byte selector for flat register images.
package lpc_reg_pkg;

    typedef enum logic [1:0] {
        LOCKED    = 2'd0,
        KEY1_WAIT = 2'd1,
        UNLOCKED  = 2'd2
    } lock_state_t;

    localparam logic [7:0] DEF_KEY0      = 8'h55;
    localparam logic [7:0] DEF_KEY1      = 8'hAA;
    localparam logic [7:0] DEF_LOCK_ADDR = 8'hFF;

    // Largest bank reg_slice can address; callers zero-extend to FLAT_W.
    localparam int MAX_REGS = 256;
    localparam int FLAT_W   = MAX_REGS * 8;

    function automatic logic [7:0] reg_slice(input logic [FLAT_W-1:0] flat,
                                             input logic [7:0] n);
        return flat[{n, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lpc_reg_lock.sv
// Key-sequence write-protect lock: KEY0 then KEY1 written to the lock address
// unlocks; any further lock write or an idle timeout relocks.
module lpc_reg_lock
    import lpc_reg_pkg::*;
#(
    parameter logic [7:0] KEY0           = DEF_KEY0,
    parameter logic [7:0] KEY1           = DEF_KEY1,
    parameter int         UNLOCK_TIMEOUT = 1024
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       Wr,
    input  logic       LockHit,
    input  logic [7:0] DataWrSW,
    output logic       Unlocked,
    output logic [1:0] StateCode
);

    localparam int CNT_W = (UNLOCK_TIMEOUT > 1) ? $clog2(UNLOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((UNLOCK_TIMEOUT > 0) ? UNLOCK_TIMEOUT - 1 : 0);

    lock_state_t      stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             timeoutHit;

    assign timeoutHit = (UNLOCK_TIMEOUT != 0) && (cntReg == CNT_LAST);

    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            LOCKED: begin
                if (Wr && LockHit && (DataWrSW == KEY0))
                    stateNext = KEY1_WAIT;
            end
            KEY1_WAIT: begin
                // Any write, wherever it lands, ends the key sequence.
                if (Wr)
                    stateNext = (LockHit && (DataWrSW == KEY1)) ? UNLOCKED : LOCKED;
            end
            UNLOCKED: begin
                if ((Wr && LockHit) || (!Wr && timeoutHit))
                    stateNext = LOCKED;
            end
            default: stateNext = LOCKED;
        endcase
    end

    always_comb begin
        cntNext = cntReg + 1'b1;
        if ((stateReg != UNLOCKED) || Wr || (UNLOCK_TIMEOUT == 0))
            cntNext = '0;
    end

    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            stateReg <= LOCKED;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    assign Unlocked  = (stateReg == UNLOCKED);
    assign StateCode = stateReg;

endmodule

// File: rtl/lpc_reg_bank.sv
// Parametrised LPC register bank with per-bit access types, key lock,
// registered reads, aggregated interrupt and write-error pulse.
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int                    NUM_REGS       = 32,
    parameter int                    ADDR_W         = 8,
    parameter logic [NUM_REGS*8-1:0] RESET_VAL      = '0,
    parameter logic [NUM_REGS*8-1:0] WR_MASK        = '1,
    parameter logic [NUM_REGS*8-1:0] HW_MASK        = '0,
    parameter logic [NUM_REGS*8-1:0] W1C_MASK       = '0,
    parameter logic [NUM_REGS*8-1:0] RC_MASK        = '0,
    parameter logic [NUM_REGS*8-1:0] IRQ_MASK       = '0,
    parameter logic [NUM_REGS-1:0]   PROT_REGS      = '0,
    parameter logic [ADDR_W-1:0]     LOCK_ADDR      = ADDR_W'(DEF_LOCK_ADDR),
    parameter logic [7:0]            KEY0           = DEF_KEY0,
    parameter logic [7:0]            KEY1           = DEF_KEY1,
    parameter int                    UNLOCK_TIMEOUT = 1024
) (
    input  logic                  LpcClock,
    input  logic                  PciReset,
    input  logic [ADDR_W-1:0]     Addr,
    input  logic                  Wr,
    input  logic                  Rd,
    input  logic [7:0]            DataWrSW,
    input  logic [NUM_REGS*8-1:0] HwVal,
    input  logic [NUM_REGS*8-1:0] HwEvent,
    output logic [NUM_REGS*8-1:0] RegOut,
    output logic [7:0]            DataRd,
    output logic                  RdValid,
    output logic                  Irq,
    output logic                  Unlocked,
    output logic                  WrErr
);

    logic [NUM_REGS*8-1:0] regFlatReg, regFlatNext;
    logic [NUM_REGS-1:0]   wrHit, rdHit;
    logic [7:0]            dataRdReg, readByte;
    logic                  rdValidReg, irqReg, wrErrReg;
    logic                  inRange, lockHit, wrReject;
    logic [1:0]            stateCode;

    assign inRange = ({1'b0, Addr} < (ADDR_W + 1)'(NUM_REGS));
    assign lockHit = (Addr == LOCK_ADDR);

    lpc_reg_lock #(
        .KEY0           (KEY0),
        .KEY1           (KEY1),
        .UNLOCK_TIMEOUT (UNLOCK_TIMEOUT)
    ) uLock (
        .LpcClock  (LpcClock),
        .PciReset  (PciReset),
        .Wr        (Wr),
        .LockHit   (lockHit),
        .DataWrSW  (DataWrSW),
        .Unlocked  (Unlocked),
        .StateCode (stateCode)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gRegs
            // Masks are made disjoint so the per-bit precedence is fixed at elaboration.
            localparam logic [7:0] HWM    = HW_MASK[8*gi +: 8];
            localparam logic [7:0] W1CM   = W1C_MASK[8*gi +: 8] & ~HWM;
            localparam logic [7:0] RCM    = RC_MASK[8*gi +: 8] & ~HWM & ~W1CM;
            localparam logic [7:0] WRM    = WR_MASK[8*gi +: 8] & ~HWM & ~W1CM & ~RCM;
            localparam logic [7:0] CONSTM = ~(HWM | W1CM | RCM | WRM);
            localparam logic [7:0] RSTV   = RESET_VAL[8*gi +: 8];

            logic [7:0] cur, evt;
            logic       wrLoad;

            assign cur       = regFlatReg[8*gi +: 8];
            assign evt       = HwEvent[8*gi +: 8];
            assign wrHit[gi] = Wr && (Addr == ADDR_W'(gi));
            assign rdHit[gi] = Rd && (Addr == ADDR_W'(gi));
            assign wrLoad    = wrHit[gi] && (!PROT_REGS[gi] || Unlocked);

            assign regFlatNext[8*gi +: 8] =
                  (HWM    & HwVal[8*gi +: 8])
                | (W1CM   & ((cur & ~({8{wrHit[gi]}} & DataWrSW)) | evt))
                | (RCM    & ((cur & ~{8{rdHit[gi]}}) | evt))
                | (WRM    & (wrLoad ? DataWrSW : cur))
                | (CONSTM & RSTV);
        end
    endgenerate

    assign wrReject = ((|(wrHit & PROT_REGS)) && !Unlocked)
                    || (Wr && !inRange && !lockHit);

    always_comb begin
        readByte = 8'hFF;
        if (inRange)
            readByte = reg_slice(FLAT_W'(regFlatReg), 8'(Addr));
        else if (lockHit)
            readByte = {6'b0, stateCode};
    end

    always_ff @(posedge LpcClock) begin
        if (!PciReset) begin
            regFlatReg <= RESET_VAL;
            dataRdReg  <= 8'h00;
            rdValidReg <= 1'b0;
            wrErrReg   <= 1'b0;
            irqReg     <= 1'b0;
        end else begin
            regFlatReg <= regFlatNext;
            rdValidReg <= Rd;
            wrErrReg   <= wrReject;
            irqReg     <= |(regFlatReg & IRQ_MASK);
            if (Rd)
                dataRdReg <= readByte;
        end
    end

    assign RegOut  = regFlatReg;
    assign DataRd  = dataRdReg;
    assign RdValid = rdValidReg;
    assign Irq     = irqReg;
    assign WrErr   = wrErrReg;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Directed bench for lpc_reg_bank: 12 registers with protected, W1C, RC and
// HW-driven bits, a 16-cycle unlock timeout and the default key bytes.
module tb_lpc_reg_bank;

    localparam int NR = 12;
    localparam logic [NR*8-1:0] RST =
        {8'hB0, 8'hAA, 8'h90, 8'h88, 8'h70, 8'h66, 8'h55, 8'hC6, 8'h33, 8'h22, 8'h11, 8'h00};
    localparam logic [NR*8-1:0] WRM  = 96'hFFFF00FF_FFFFFF1B_FFFFFFFF;
    localparam logic [NR*8-1:0] HWM  = 96'h00000000_0F000000_00000000;
    localparam logic [NR*8-1:0] W1CM = 96'h00000100_00000000_00000000;
    localparam logic [NR*8-1:0] RCM  = 96'h01000000_00000000_00000000;
    localparam logic [NR*8-1:0] IRQM = 96'h01000100_00000000_00000000;

    logic            LpcClock = 1'b0;
    logic            PciReset;
    logic [7:0]      Addr;
    logic            Wr, Rd;
    logic [7:0]      DataWrSW;
    logic [NR*8-1:0] HwVal, HwEvent;
    logic [NR*8-1:0] RegOut;
    logic [7:0]      DataRd;
    logic            RdValid, Irq, Unlocked, WrErr;

    int compared   = 0;
    int mismatched = 0;

    always #5 LpcClock = ~LpcClock;

    lpc_reg_bank #(
        .NUM_REGS       (NR),
        .ADDR_W         (8),
        .RESET_VAL      (RST),
        .WR_MASK        (WRM),
        .HW_MASK        (HWM),
        .W1C_MASK       (W1CM),
        .RC_MASK        (RCM),
        .IRQ_MASK       (IRQM),
        .PROT_REGS      (12'h010),
        .LOCK_ADDR      (8'hFF),
        .KEY0           (8'h55),
        .KEY1           (8'hAA),
        .UNLOCK_TIMEOUT (16)
    ) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .Addr     (Addr),
        .Wr       (Wr),
        .Rd       (Rd),
        .DataWrSW (DataWrSW),
        .HwVal    (HwVal),
        .HwEvent  (HwEvent),
        .RegOut   (RegOut),
        .DataRd   (DataRd),
        .RdValid  (RdValid),
        .Irq      (Irq),
        .Unlocked (Unlocked),
        .WrErr    (WrErr)
    );

    task automatic tick();
        @(posedge LpcClock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        Addr = a; DataWrSW = d; Wr = 1'b1;
        tick();
        Wr = 1'b0;
        $display("WR  addr=%02h data=%02h wrerr=%0b unlocked=%0b", a, d, WrErr, Unlocked);
    endtask

    task automatic rd(input logic [7:0] a);
        Addr = a; Rd = 1'b1;
        tick();
        Rd = 1'b0;
        $display("RD  addr=%02h data=%02h valid=%0b", a, DataRd, RdValid);
    endtask

    task automatic chk(input string tag, input logic [NR*8-1:0] obs, input logic [NR*8-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rbyte(input logic [NR*8-1:0] f, input int n);
        return f[8*n +: 8];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NR*8-1:0] rstImg;
        rstImg = RST;
        PciReset = 1'b0; Addr = '0; Wr = 1'b0; Rd = 1'b0; DataWrSW = '0;
        HwVal = '0; HwEvent = '0;
        tick(); tick();
        chk("reset_regout", RegOut, rstImg);
        chk("reset_rdvalid", RdValid, 0);
        chk("reset_wrerr", WrErr, 0);
        chk("reset_dataRd", DataRd, 0);
        chk("reset_unlocked", Unlocked, 0);
        chk("reset_irq", Irq, 0);
        PciReset = 1'b1;

        for (int i = 0; i < NR; i++) begin
            rd(8'(i));
            chk($sformatf("rst_read_%0d", i), DataRd, rbyte(rstImg, i));
            chk($sformatf("rst_rdvalid_%0d", i), RdValid, 1);
        end
        tick();
        chk("rdvalid_single", RdValid, 0);

        // Protected register while locked
        wr(8'h04, 8'hFF);
        chk("prot_wrerr", WrErr, 1);
        chk("prot_unchanged", rbyte(RegOut, 4), 8'hC6);
        tick();
        chk("wrerr_pulse", WrErr, 0);

        // Unlock and write protected register
        wr(8'hFF, 8'h55);
        chk("key0_locked", Unlocked, 0);
        wr(8'hFF, 8'hAA);
        chk("unlocked", Unlocked, 1);
        rd(8'hFF);
        chk("lock_code_unlocked", DataRd, 8'h02);
        wr(8'h04, 8'hFF);
        chk("prot_write_ok", rbyte(RegOut, 4), 8'hDF);
        chk("prot_no_wrerr", WrErr, 0);
        wr(8'hFF, 8'h00);
        chk("relock", Unlocked, 0);
        wr(8'h20, 8'h12);
        chk("oor_wrerr", WrErr, 1);
        rd(8'h20);
        chk("oor_read", DataRd, 8'hFF);

        // W1C bit 0 of reg 9
        HwEvent[72] = 1'b1; tick(); HwEvent = '0;
        chk("w1c_set", rbyte(RegOut, 9), 8'h91);
        chk("w1c_irq_lag", Irq, 0);
        tick();
        chk("w1c_irq", Irq, 1);
        HwEvent[72] = 1'b1; wr(8'h09, 8'h01); HwEvent = '0;
        chk("w1c_set_wins", rbyte(RegOut, 9), 8'h91);
        wr(8'h09, 8'h01);
        chk("w1c_clear", rbyte(RegOut, 9), 8'h90);
        chk("w1c_irq_hold", Irq, 1);
        tick();
        chk("w1c_irq_clear", Irq, 0);

        // RC bit 0 of reg 11
        HwEvent[88] = 1'b1; tick(); HwEvent = '0;
        chk("rc_set", rbyte(RegOut, 11), 8'hB1);
        tick();
        chk("rc_irq", Irq, 1);
        rd(8'h0B);
        chk("rc_read_pre", DataRd, 8'hB1);
        chk("rc_cleared", rbyte(RegOut, 11), 8'hB0);
        rd(8'h0B);
        chk("rc_read_again", DataRd, 8'hB0);
        chk("rc_irq_clear", Irq, 0);

        // HW-driven low nibble of reg 7
        HwVal[63:56] = 8'hF5; tick();
        chk("hw_load", rbyte(RegOut, 7), 8'h75);
        wr(8'h07, 8'h3C);
        chk("hw_mixed_write", rbyte(RegOut, 7), 8'h35);
        rd(8'h07);
        chk("hw_read", DataRd, 8'h35);

        // Simultaneous read and write
        Addr = 8'h02; DataWrSW = 8'h5A; Wr = 1'b1; Rd = 1'b1;
        tick();
        Wr = 1'b0; Rd = 1'b0;
        $display("RDWR addr=02 data=5A read=%02h", DataRd);
        chk("rdwr_read_old", DataRd, 8'h22);
        chk("rdwr_valid", RdValid, 1);
        chk("rdwr_written", rbyte(RegOut, 2), 8'h5A);

        // Interrupted key sequence
        wr(8'hFF, 8'h55);
        wr(8'h02, 8'h11);
        chk("interrupt_write", rbyte(RegOut, 2), 8'h11);
        wr(8'hFF, 8'hAA);
        chk("interrupt_locked", Unlocked, 0);
        rd(8'hFF);
        chk("interrupt_code", DataRd, 8'h00);

        // Timeout
        wr(8'hFF, 8'h55);
        wr(8'hFF, 8'hAA);
        chk("to_unlocked", Unlocked, 1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("to_hold_%0d", i), Unlocked, 1);
        end
        tick();
        chk("to_relock", Unlocked, 0);

        // Reset in KEY1_WAIT with a read pending
        wr(8'hFF, 8'h55);
        rd(8'hFF);
        chk("key1wait_code", DataRd, 8'h01);
        Addr = 8'hFF; Rd = 1'b1; PciReset = 1'b0;
        tick();
        Rd = 1'b0;
        $display("RST mid-sequence regout=%0h", RegOut);
        chk("mid_rst_regout", RegOut, rstImg);
        chk("mid_rst_rdvalid", RdValid, 0);
        chk("mid_rst_dataRd", DataRd, 0);
        chk("mid_rst_unlocked", Unlocked, 0);
        PciReset = 1'b1;
        wr(8'hFF, 8'hAA);
        chk("mid_rst_key_lost", Unlocked, 0);
        rd(8'hFF);
        chk("mid_rst_code", DataRd, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lpc_reg_bank.md
Name: lpc_reg_bank

Overview:
- Parametrised LPC-side register bank; next generation of the fixed 32-entry CPLD register file.
- Register count, reset image and per-bit access type (RW / RO / HW-driven / W1C sticky / read-clear) are set by parameters.
- Adds a key-sequence write-protect lock with auto-relock timeout, an aggregated interrupt output, registered read data, and a write-error flag.
- Sits between the LPC target decoder (Addr/Wr/Rd/DataWrSW) and board-control logic.

Parameters:
- NUM_REGS, 32: number of 8-bit registers, 1..(2**ADDR_W - 1).
- ADDR_W, 8: address width.
- RESET_VAL, all 0: NUM_REGS*8-bit packed reset image; register n at bits [8n+7:8n].
- WR_MASK, all 1: RW bits writable by software.
- HW_MASK, 0: bits loaded from HwVal every cycle.
- W1C_MASK, 0: sticky event bits; set by HwEvent, cleared by writing 1.
- RC_MASK, 0: sticky event bits; set by HwEvent, cleared by a read of that register.
- IRQ_MASK, 0: W1C/RC bits that contribute to Irq.
- PROT_REGS, 0: NUM_REGS-bit vector; 1 = register write-protected while locked.
- LOCK_ADDR, 8'hFF: lock/key register address; must be >= NUM_REGS.
- KEY0 / KEY1, 8'h55 / 8'hAA: unlock key bytes.
- UNLOCK_TIMEOUT, 1024: cycles without any Wr before auto-relock; 0 = never.

Ports:
- LpcClock  in  1  33 MHz LPC clock.
- PciReset  in  1  reset: one clock; reset is synchronous and active-low.
- Addr  in  ADDR_W  register address.
- Wr  in  1  single-cycle write strobe.
- Rd  in  1  single-cycle read strobe.
- DataWrSW  in  8  write data.
- HwVal  in  NUM_REGS*8  live hardware values for HW_MASK bits.
- HwEvent  in  NUM_REGS*8  single-cycle set pulses for W1C/RC bits.
- RegOut  out  NUM_REGS*8  current register contents, flat.
- DataRd  out  8  read data.
- RdValid  out  1  DataRd valid pulse.
- Irq  out  1  OR of set IRQ_MASK bits.
- Unlocked  out  1  lock FSM is in UNLOCKED.
- WrErr  out  1  rejected-write pulse.

Behaviour:
- Reset (PciReset low at a LpcClock edge):
  - RegOut = RESET_VAL.
  - DataRd = 0, RdValid = 0, WrErr = 0.
  - Lock FSM = LOCKED, timeout counter = 0.
- Per-bit precedence, evaluated at each edge:
  1. HW_MASK: bit takes HwVal; writes are ignored.
  2. W1C_MASK: next = (cur & ~(Wr & hit & DataWrSW)) | HwEvent. Set wins over a simultaneous clear.
  3. RC_MASK: next = (cur & ~(Rd & hit)) | HwEvent. Set wins; writes are ignored.
  4. WR_MASK: loads DataWrSW on Wr & hit & permitted.
  5. Any other bit: holds its RESET_VAL constant.
- hit = (Addr == n). permitted = !PROT_REGS[n] | Unlocked.
- Read timing:
  - Rd at edge k gives DataRd valid and RdValid = 1 for exactly cycle k+1.
  - The returned value is the pre-edge contents, including RC bits about to clear.
  - Addr == LOCK_ADDR returns {6'b0, state code}: LOCKED=0, KEY1_WAIT=1, UNLOCKED=2.
  - Any other out-of-range address returns 8'hFF.
- Simultaneous Wr and Rd to the same address: the read returns the pre-write value and the write still takes effect.
- Lock FSM (writes to LOCK_ADDR only):
  - LOCKED: data == KEY0 goes to KEY1_WAIT; otherwise stays LOCKED.
  - KEY1_WAIT: data == KEY1 goes to UNLOCKED; otherwise goes to LOCKED. A Wr to any other address also returns to LOCKED.
  - UNLOCKED: any write to LOCK_ADDR goes to LOCKED.
- Timeout:
  - The counter runs only in UNLOCKED and clears on every Wr.
  - When it reaches UNLOCK_TIMEOUT-1 with no Wr, the FSM goes to LOCKED next edge.
- WrErr: 1-cycle pulse, the cycle after Wr to a protected register while locked, or Wr to an out-of-range address other than LOCK_ADDR. The register is unchanged.
- Irq: registered, 1 cycle after the source bit changes; level, not pulse.
- Reset mid-sequence (e.g. in KEY1_WAIT, or with RdValid pending) discards all state; no RdValid after reset.

Decomposition:
- Package lpc_reg_pkg holds:
  - lock_state_t enum (LOCKED, KEY1_WAIT, UNLOCKED).
  - Default KEY0/KEY1 and LOCK_ADDR constants.
  - Function reg_slice(flat, n) returning byte n.
- One sub-module, lpc_reg_lock, contains the key FSM, timeout counter and Unlocked output.

Test Plan:
- Reset then read regs 0..NUM_REGS-1 -> DataRd equals RESET_VAL bytes; RdValid asserted one cycle after each Rd.
- Set PROT_REGS[4]=1, WR_MASK[reg4]=8'h1B; write 8'hFF to 4 while locked -> reg4 unchanged, WrErr=1. Write 8'h55 then 8'hAA to 8'hFF, then 8'hFF to 4 -> reg4 = (RESET & 8'hE4) | 8'h1B.
- W1C bit 0 of reg 9 with IRQ_MASK: HwEvent pulse -> bit=1 and Irq=1 one cycle later. Write 8'h01 with a coincident HwEvent -> bit stays 1. Write 8'h01 alone -> bit=0, Irq=0.
- RC bit in reg 11: event then Rd -> DataRd shows 1 and the bit clears. Second Rd -> 0.
- KEY0 followed by a write to reg 2, then KEY1 -> FSM stays LOCKED and a read of 8'hFF returns 8'h00.
- Unlock with UNLOCK_TIMEOUT=16 and no writes -> Unlocked drops after 16 cycles. Unlock again, then assert PciReset low for one edge while in KEY1_WAIT -> LOCKED and RegOut=RESET_VAL.
